// File: rtl/buart_param_if.sv
// CPU-side bus of the parametrised UART: transmit strobe/data,
// RX FIFO pop/head and sticky error flags.
interface buart_param_if;
    logic       wr;
    logic [7:0] tx_data;
    logic       busy;
    logic       rd;
    logic       valid;
    logic [7:0] rx_data;
    logic [2:0] err;
    logic       clr_err;

    modport master (
        output wr, tx_data, rd, clr_err,
        input  busy, valid, rx_data, err
    );

    modport slave (
        input  wr, tx_data, rd, clr_err,
        output busy, valid, rx_data, err
    );
endinterface

// File: rtl/buart_param.sv
// Parametrised full-duplex UART: configurable frame format,
// RX FIFO, false-start rejection and sticky error flags.
module buart_param #(
    parameter int CLKFREQ  = 12000000,
    parameter int BAUD     = 115200,
    parameter int DATABITS = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1,
    parameter int RXDEPTH  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx,
    buart_param_if.slave b
);
    localparam int DIV  = CLKFREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(RXDEPTH);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [2:0] LAST_D = 3'(DATABITS - 1);
    localparam logic [2:0] LAST_S = 3'(STOPBITS - 1);
    localparam logic [7:0] MASK   = 8'((16'd1 << DATABITS) - 16'd1);
    localparam logic ODD    = (PARITY == 1);
    localparam logic HASPAR = (PARITY != 0);
    localparam logic [AW:0] FULL = (AW+1)'(RXDEPTH);

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PAR, T_STOP
    } tx_st_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT
    } rx_st_t;

    tx_st_t        ts_q, ts_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    tbit_q, tbit_d;
    logic [7:0]    tsh_q, tsh_d;
    logic          tpar_q, tpar_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          tend;
    logic [7:0]    tx_m;

    rx_st_t        rs_q, rs_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [2:0]    rbit_q, rbit_d;
    logic [7:0]    rsh_q, rsh_d;
    logic          rpar_q, rpar_d;
    logic          s1_q, s2_q, s3_q;
    logic          rhit, push, set_fe, set_pe;
    logic [7:0]    rword;

    logic [7:0]    mem_q [RXDEPTH];
    logic [7:0]    mem_d [RXDEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [2:0]    err_q, err_d;
    logic          pop, full, wen;

    assign tx_m = b.tx_data & MASK;
    assign tend = (tcnt_q == DIV_M1);

    always_comb begin
        ts_d   = ts_q;
        tcnt_d = tend ? '0 : tcnt_q + 1'b1;
        tbit_d = tbit_q;
        tsh_d  = tsh_q;
        tpar_d = tpar_q;
        tx_d   = tx_q;
        busy_d = busy_q;
        unique case (ts_q)
            T_IDLE: begin
                tcnt_d = '0;
                if (b.wr) begin
                    ts_d   = T_START;
                    tx_d   = 1'b0;
                    busy_d = 1'b1;
                    tsh_d  = tx_m;
                    tpar_d = (^tx_m) ^ ODD;
                end
            end
            T_START: if (tend) begin
                ts_d   = T_DATA;
                tbit_d = '0;
                tx_d   = tsh_q[0];
            end
            T_DATA: if (tend) begin
                if (tbit_q == LAST_D) begin
                    tbit_d = '0;
                    ts_d   = HASPAR ? T_PAR : T_STOP;
                    tx_d   = HASPAR ? tpar_q : 1'b1;
                end else begin
                    tbit_d = tbit_q + 1'b1;
                    tsh_d  = {1'b0, tsh_q[7:1]};
                    tx_d   = tsh_q[1];
                end
            end
            T_PAR: if (tend) begin
                ts_d   = T_STOP;
                tbit_d = '0;
                tx_d   = 1'b1;
            end
            T_STOP: if (tend) begin
                if (tbit_q == LAST_S) begin
                    ts_d   = T_IDLE;
                    busy_d = 1'b0;
                end else begin
                    tbit_d = tbit_q + 1'b1;
                end
            end
            default: ts_d = T_IDLE;
        endcase
    end

    // START samples half a bit after the edge, later samples hit bit centres
    assign rhit = (rs_q == R_START) ? (rcnt_q == HALF_M1)
                                    : (rcnt_q == DIV_M1);
    assign rword = 8'(rsh_q >> (8 - DATABITS));

    always_comb begin
        rs_d   = rs_q;
        rcnt_d = rhit ? '0 : rcnt_q + 1'b1;
        rbit_d = rbit_q;
        rsh_d  = rsh_q;
        rpar_d = rpar_q;
        push   = 1'b0;
        set_fe = 1'b0;
        set_pe = 1'b0;
        unique case (rs_q)
            R_IDLE: begin
                rcnt_d = '0;
                if (s3_q && !s2_q) rs_d = R_START;
            end
            R_START: if (rhit) begin
                if (s2_q) begin
                    rs_d = R_IDLE;
                end else begin
                    rs_d   = R_DATA;
                    rbit_d = '0;
                    rpar_d = ODD;
                end
            end
            R_DATA: if (rhit) begin
                rsh_d  = {s2_q, rsh_q[7:1]};
                rpar_d = rpar_q ^ s2_q;
                if (rbit_q == LAST_D) rs_d = HASPAR ? R_PAR : R_STOP;
                else rbit_d = rbit_q + 1'b1;
            end
            R_PAR: if (rhit) begin
                rpar_d = rpar_q ^ s2_q;
                rs_d   = R_STOP;
            end
            R_STOP: if (rhit) begin
                rs_d = s2_q ? R_IDLE : R_WAIT;
                if (!s2_q) set_fe = 1'b1;
                else if (HASPAR && rpar_q) set_pe = 1'b1;
                else push = 1'b1;
            end
            R_WAIT: begin
                rcnt_d = '0;
                if (s2_q) rs_d = R_IDLE;
            end
            default: rs_d = R_IDLE;
        endcase
    end

    assign pop  = b.rd && (cnt_q != '0);
    assign full = (cnt_q == FULL);
    assign wen  = push && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (wen) begin
            mem_d[wp_q] = rword;
            wp_d = wp_q + 1'b1;
        end
        if (pop) rp_d = rp_q + 1'b1;
        cnt_d = cnt_q + (AW+1)'(wen) - (AW+1)'(pop);
        err_d = b.clr_err ? 3'b000 : err_q;
        err_d = err_d | {push && full && !pop, set_pe, set_fe};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q   <= T_IDLE;
            tcnt_q <= '0;
            tbit_q <= '0;
            tsh_q  <= '0;
            tpar_q <= 1'b0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            rs_q   <= R_IDLE;
            rcnt_q <= '0;
            rbit_q <= '0;
            rsh_q  <= '0;
            rpar_q <= 1'b0;
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            s3_q   <= 1'b1;
            mem_q  <= '{default: '0};
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
        end else begin
            ts_q   <= ts_d;
            tcnt_q <= tcnt_d;
            tbit_q <= tbit_d;
            tsh_q  <= tsh_d;
            tpar_q <= tpar_d;
            tx_q   <= tx_d;
            busy_q <= busy_d;
            rs_q   <= rs_d;
            rcnt_q <= rcnt_d;
            rbit_q <= rbit_d;
            rsh_q  <= rsh_d;
            rpar_q <= rpar_d;
            s1_q   <= rx;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            mem_q  <= mem_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign tx        = tx_q;
    assign b.busy    = busy_q;
    assign b.valid   = (cnt_q != '0);
    assign b.rx_data = mem_q[rp_q];
    assign b.err     = err_q;
endmodule

// File: tb/tb_buart_param.sv
// Directed bench: default 8N1, looped-back 7E2 and 8O1 instances
// exercised for framing, FIFO, error flags and reset behaviour.
module tb_buart_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx0 = 1'b1;
    logic rx2 = 1'b1;
    logic tx0, tx1, tx2;
    int checks = 0;
    int passed = 0;
    logic [9:0]  f10;
    logic [10:0] f11;

    buart_param_if w0 ();
    buart_param_if w1 ();
    buart_param_if w2 ();

    always #5 clk = ~clk;

    buart_param u0 (
        .clk(clk), .reset(reset), .rx(rx0), .tx(tx0), .b(w0)
    );
    buart_param #(.PARITY(2), .DATABITS(7), .STOPBITS(2)) u1 (
        .clk(clk), .reset(reset), .rx(tx1), .tx(tx1), .b(w1)
    );
    buart_param #(.PARITY(1)) u2 (
        .clk(clk), .reset(reset), .rx(rx2), .tx(tx2), .b(w2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input int sel, input logic [15:0] bits,
                            input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx0 = bits[i];
            else rx2 = bits[i];
            cyc(104);
        end
    endtask

    initial begin
        w0.wr = 0; w0.tx_data = 0; w0.rd = 0; w0.clr_err = 0;
        w1.wr = 0; w1.tx_data = 0; w1.rd = 0; w1.clr_err = 0;
        w2.wr = 0; w2.tx_data = 0; w2.rd = 0; w2.clr_err = 0;
        cyc(3);
        chk("rst_tx", tx0, 1);
        chk("rst_busy", w0.busy, 0);
        chk("rst_valid", w0.valid, 0);
        chk("rst_rx_data", w0.rx_data, 0);
        chk("rst_err", w0.err, 0);
        reset = 1'b0;
        cyc(2);

        // 8N1 0x55, with a wr attempt in the middle of the frame
        f10 = {1'b1, 8'h55, 1'b0};
        w0.tx_data = 8'h55; w0.wr = 1;
        cyc(1);
        w0.wr = 0;
        for (int c = 0; c < 1040; c++) begin
            if (c % 104 == 0 || c % 104 == 103)
                chk("t1_bit", tx0, f10[c/104]);
            if (c == 0 || c == 1039) chk("t1_busy_hi", w0.busy, 1);
            if (c == 300) begin w0.wr = 1; w0.tx_data = 8'h00; end
            if (c == 301) w0.wr = 0;
            cyc(1);
        end
        chk("t1_busy_lo", w0.busy, 0);
        chk("t1_tx_idle", tx0, 1);

        // 7E2 0x41 looped back into its own receiver
        f11 = {2'b11, 1'b0, 7'h41, 1'b0};
        w1.tx_data = 8'h41; w1.wr = 1;
        cyc(1);
        w1.wr = 0;
        for (int c = 0; c < 1144; c++) begin
            if (c % 104 == 52) chk("t2_bit", tx1, f11[c/104]);
            if (c == 1143) chk("t2_busy_hi", w1.busy, 1);
            cyc(1);
        end
        chk("t2_busy_lo", w1.busy, 0);
        chk("t2_valid", w1.valid, 1);
        chk("t2_rx_data", w1.rx_data, 8'h41);
        chk("t2_err", w1.err, 0);
        w1.rd = 1;
        cyc(1);
        w1.rd = 0;
        chk("t2_valid_pop", w1.valid, 0);

        // glitch shorter than half a bit
        rx0 = 0;
        cyc(26);
        rx0 = 1;
        cyc(300);
        chk("t3_valid", w0.valid, 0);
        chk("t3_err", w0.err, 0);

        // five bytes into a four-deep FIFO
        for (int k = 1; k <= 5; k++)
            rx_frame(0, {6'b0, 1'b1, 8'(k), 1'b0}, 10);
        cyc(10);
        chk("t4_err_ovr", w0.err, 3'b100);
        for (int k = 1; k <= 4; k++) begin
            chk("t4_valid", w0.valid, 1);
            chk("t4_rx_data", w0.rx_data, k);
            w0.rd = 1;
            cyc(1);
            w0.rd = 0;
        end
        chk("t4_empty", w0.valid, 0);
        w0.rd = 1;
        cyc(1);
        w0.rd = 0;
        chk("t4_pop_empty", w0.valid, 0);
        w0.clr_err = 1;
        cyc(1);
        w0.clr_err = 0;
        chk("t4_err_clr", w0.err, 0);

        // bad stop bit followed by a long break
        rx_frame(0, {6'b0, 1'b0, 8'hA5, 1'b0}, 10);
        cyc(3 * 1040);
        rx0 = 1;
        cyc(200);
        chk("t5_err_fe", w0.err, 3'b001);
        chk("t5_valid", w0.valid, 0);
        rx_frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        cyc(10);
        chk("t5_valid_good", w0.valid, 1);
        chk("t5_rx_data", w0.rx_data, 8'h3C);
        chk("t5_err_sticky", w0.err, 3'b001);

        // 8O1: wrong parity on 0x03, then correct parity on 0x07
        rx_frame(2, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        cyc(10);
        chk("t6_err_pe", w2.err, 3'b010);
        chk("t6_valid", w2.valid, 0);
        rx_frame(2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        cyc(10);
        chk("t6_valid_good", w2.valid, 1);
        chk("t6_rx_data", w2.rx_data, 8'h07);
        chk("t6_err_keep", w2.err, 3'b010);

        // reset in the middle of a transmit
        w2.tx_data = 8'h00; w2.wr = 1;
        cyc(1);
        w2.wr = 0;
        cyc(300);
        chk("t7_busy_mid", w2.busy, 1);
        chk("t7_tx_mid", tx2, 0);
        reset = 1;
        cyc(1);
        reset = 0;
        chk("t7_tx", tx2, 1);
        chk("t7_busy", w2.busy, 0);
        chk("t7_valid", w2.valid, 0);
        chk("t7_err", w2.err, 0);
        chk("t7_rx_data", w2.rx_data, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
